// File: rtl/ps2_key_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_key_tracker
// Purpose  : PS/2 receiver with glitch filter, E0/F0 decode and held-key levels
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clr_held,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic [6:0] note_held,
  output logic [3:0] arrow_held,
  output logic       oct_up_held,
  output logic       oct_down_held
);

  localparam int c_filt_w = $clog2(FILTER_LEN + 1);
  localparam int c_to_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_data   = 2'd1;
  localparam logic [1:0] c_st_parity = 2'd2;
  localparam logic [1:0] c_st_stop   = 2'd3;

  logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                r_filt, r_filt_prev;
  logic [c_filt_w-1:0] r_filt_cnt;
  logic                w_fall;

  logic [1:0]          r_state, w_state_nxt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_par;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_byte_ok;
  logic                w_timeout, w_shift_en, w_par_en, w_stop_ok, w_stop_bad;

  logic                r_ext, r_brk;
  logic                w_make;

  // Filtered clock only follows the synchronised line after FILTER_LEN disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1    <= 1'b0;
      r_clk_s2    <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
      r_filt      <= 1'b0;
      r_filt_prev <= 1'b0;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_filt_last) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + c_filt_w'(1);
      end
    end
  end

  assign w_fall    = r_filt_prev & ~r_filt;
  assign w_timeout = (r_state != c_st_idle) && !w_fall && (r_to_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = c_st_idle;
    end else if (w_fall) begin
      case (r_state)
        c_st_idle:   if (!r_dat_s2) w_state_nxt = c_st_data;
        c_st_data:   if (r_bit_cnt == 3'd7) w_state_nxt = c_st_parity;
        c_st_parity: w_state_nxt = c_st_stop;
        default:     w_state_nxt = c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    if (w_fall) begin
      case (r_state)
        c_st_data:   w_shift_en = 1'b1;
        c_st_parity: w_par_en   = 1'b1;
        c_st_stop: begin
          w_stop_ok  = r_dat_s2 & (^{r_shift, r_par});
          w_stop_bad = ~(r_dat_s2 & (^{r_shift, r_par}));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_byte_ok <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_byte_ok <= w_stop_ok;
      frame_err <= w_stop_bad | w_timeout;
      if (w_fall || r_state == c_st_idle) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + c_to_w'(1);
      if (r_state == c_st_idle) r_bit_cnt <= '0;
      else if (w_shift_en)      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};
      if (w_par_en)   r_par   <= r_dat_s2;
    end
  end

  // r_shift is stable during r_byte_ok: the FSM is back in IDLE and cannot shift yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_ok) begin
        case (r_shift)
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_brk <= 1'b1;
          8'hE1: begin end
          8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
          default: begin
            key_valid   <= 1'b1;
            key_code    <= r_shift;
            key_ext     <= r_ext;
            key_release <= r_brk;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_make = ~key_release;

  always_ff @(posedge clk) begin
    if (rst || clr_held) begin
      note_held     <= '0;
      arrow_held    <= '0;
      oct_up_held   <= 1'b0;
      oct_down_held <= 1'b0;
    end else if (key_valid) begin
      if (!key_ext) begin
        case (key_code)
          8'h16:   note_held[0]  <= w_make;
          8'h1E:   note_held[1]  <= w_make;
          8'h26:   note_held[2]  <= w_make;
          8'h25:   note_held[3]  <= w_make;
          8'h2E:   note_held[4]  <= w_make;
          8'h36:   note_held[5]  <= w_make;
          8'h3D:   note_held[6]  <= w_make;
          8'h55:   oct_up_held   <= w_make;
          8'h4E:   oct_down_held <= w_make;
          default: ;
        endcase
      end else begin
        case (key_code)
          8'h75:   arrow_held[0] <= w_make;
          8'h72:   arrow_held[1] <= w_make;
          8'h6B:   arrow_held[2] <= w_make;
          8'h74:   arrow_held[3] <= w_make;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_tracker
// Purpose  : Directed + randomized PS/2 frames checked against a byte-level key model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HP          = 20;
  localparam int LAT         = 2 + FILTER_LEN + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        clr_held = 1'b0;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_release;
  logic        frame_err;
  logic [6:0]  note_held;
  logic [3:0]  arrow_held;
  logic        oct_up_held;
  logic        oct_down_held;
  logic [12:0] held_vec;

  assign held_vec = {oct_down_held, oct_up_held, arrow_held, note_held};

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .clr_held      (clr_held),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_release   (key_release),
    .frame_err     (frame_err),
    .note_held     (note_held),
    .arrow_held    (arrow_held),
    .oct_up_held   (oct_up_held),
    .oct_down_held (oct_down_held)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int kv_cycles = 0, ferr_cycles = 0, both_cnt = 0, kv_cyc_last = 0, stop_cyc = 0;
  always @(negedge clk) begin
    if (key_valid) begin
      kv_cycles++;
      kv_cyc_last = cyc;
    end
    if (frame_err) ferr_cycles++;
    if (key_valid && frame_err) both_cnt++;
  end

  // Sole driver of clr_held: an immediate pulse or one aligned with the next key_valid.
  bit clr_req_tog = 0, clr_req_ack = 0, clr_arm_tog = 0, clr_arm_ack = 0;
  always @(negedge clk) begin
    clr_held = 1'b0;
    if (clr_req_tog != clr_req_ack) begin
      clr_held    = 1'b1;
      clr_req_ack = clr_req_tog;
    end else if (clr_arm_tog != clr_arm_ack && key_valid) begin
      clr_held    = 1'b1;
      clr_arm_ack = clr_arm_tog;
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: prefix flags and one held bit per mapped {ext,code} table entry.
  logic [8:0]  key_tbl [13];
  bit          m_ext = 0, m_brk = 0;
  logic [12:0] m_held = '0;

  function automatic int key_idx(input logic [7:0] code, input logic ext);
    for (int i = 0; i < 13; i++)
      if (key_tbl[i] == {ext, code}) return i;
    return -1;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // corrupt: 0 = good frame, 1 = bad parity, 2 = bad stop bit
  task automatic send_checked(input logic [7:0] b, input int corrupt, input bit clr_kv);
    int          kv0, fe0, idx;
    logic        e_kv, e_fe, e_ext, e_rel, par, stp;
    logic [10:0] fr;
    kv0 = kv_cycles;
    fe0 = ferr_cycles;
    e_kv = 1'b0;
    e_fe = 1'b0;
    e_ext = m_ext;
    e_rel = m_brk;
    par = ~^b;
    stp = 1'b1;
    if (corrupt == 1) par = ~par;
    if (corrupt == 2) stp = 1'b0;
    if (corrupt != 0) begin
      e_fe = 1'b1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1) begin
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
      m_ext = 0; m_brk = 0;
    end else begin
      e_kv = 1'b1; m_ext = 0; m_brk = 0;
      idx = key_idx(b, e_ext);
      if (clr_kv) m_held = '0;
      else if (idx >= 0) m_held[idx] = ~e_rel;
    end
    if (clr_kv) clr_arm_tog = ~clr_arm_tog;
    fr = {stp, par, b, 1'b0};
    send_bits(fr, 11);
    repeat (2 * HP) @(negedge clk);
    check("kv_pulses", kv_cycles - kv0, e_kv);
    check("ferr_pulses", ferr_cycles - fe0, e_fe);
    if (e_kv) begin
      check("key_code", key_code, b);
      check("key_ext", key_ext, e_ext);
      check("key_release", key_release, e_rel);
      check("latency", kv_cyc_last - stop_cyc, LAT);
    end
    check("held", held_vec, m_held);
  endtask

  initial begin
    int          kv0, fe0;
    logic [10:0] fr;
    logic [7:0]  sp [4];
    key_tbl[0]  = 9'h016; key_tbl[1]  = 9'h01E; key_tbl[2]  = 9'h026; key_tbl[3]  = 9'h025;
    key_tbl[4]  = 9'h02E; key_tbl[5]  = 9'h036; key_tbl[6]  = 9'h03D; key_tbl[7]  = 9'h175;
    key_tbl[8]  = 9'h172; key_tbl[9]  = 9'h16B; key_tbl[10] = 9'h174; key_tbl[11] = 9'h055;
    key_tbl[12] = 9'h04E;
    sp[0] = 8'hAA; sp[1] = 8'hFA; sp[2] = 8'hEE; sp[3] = 8'hFE;

    repeat (5) @(negedge clk);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_flags", {key_ext, key_release, frame_err}, 0);
    check("rst_held", held_vec, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send_checked(8'h16, 0, 0);
    send_checked(8'hF0, 0, 0);
    send_checked(8'h16, 0, 0);
    send_checked(8'hF0, 0, 0);
    send_checked(8'hAA, 0, 0);
    send_checked(8'hE0, 0, 0);
    send_checked(8'h75, 0, 0);
    send_checked(8'h75, 0, 0);
    send_checked(8'hE0, 0, 0);
    send_checked(8'hF0, 0, 0);
    send_checked(8'h75, 0, 0);
    send_checked(8'h1E, 1, 0);
    send_checked(8'h1E, 0, 0);

    // Frame abandoned after four data bits, with a pending E0 that must be dropped.
    send_checked(8'hE0, 0, 0);
    kv0 = kv_cycles;
    fe0 = ferr_cycles;
    fr = {1'b1, 1'b0, 8'h4E, 1'b0};
    send_bits(fr, 5);
    m_ext = 0; m_brk = 0;
    repeat (TIMEOUT_CYC + 4 * HP) @(negedge clk);
    check("timeout_ferr", ferr_cycles - fe0, 1);
    check("timeout_kv", kv_cycles - kv0, 0);
    send_checked(8'h75, 0, 0);
    send_checked(8'h4E, 0, 0);

    // Short clock glitches with data low must not start a frame.
    kv0 = kv_cycles;
    fe0 = ferr_cycles;
    ps2_data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    check("glitch_ferr", ferr_cycles - fe0, 0);
    check("glitch_kv", kv_cycles - kv0, 0);
    send_checked(8'h26, 0, 0);

    clr_req_tog = ~clr_req_tog;
    repeat (4) @(negedge clk);
    m_held = '0;
    check("clr_held", held_vec, m_held);
    send_checked(8'h3D, 0, 0);
    send_checked(8'h16, 0, 1);

    for (int n = 0; n < 60; n++) begin
      int         r, cr, corr;
      logic [7:0] b;
      r  = $urandom_range(0, 99);
      cr = $urandom_range(0, 99);
      if (r < 50)      b = key_tbl[$urandom_range(0, 12)][7:0];
      else if (r < 70) b = 8'hE0;
      else if (r < 85) b = 8'hF0;
      else if (r < 90) b = 8'hE1;
      else if (r < 95) b = sp[$urandom_range(0, 3)];
      else             b = 8'($urandom_range(0, 255));
      corr = (cr < 5) ? 1 : (cr < 9) ? 2 : 0;
      send_checked(b, corr, 0);
    end

    send_checked(8'h36, 0, 0);
    fr = {1'b1, 1'b1, 8'h2E, 1'b0};
    send_bits(fr, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_held", held_vec, 0);
    check("midrst_outs", {key_valid, key_code, key_ext, key_release, frame_err}, 0);
    rst = 1'b0;
    m_ext = 0; m_brk = 0; m_held = '0;
    fe0 = ferr_cycles;
    repeat (TIMEOUT_CYC + 4 * HP) @(negedge clk);
    check("midrst_silent", ferr_cycles - fe0, 0);
    send_checked(8'h55, 0, 0);

    check("kv_ferr_excl", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
